// File: rtl/psram_arbiter.sv
// Two-requester round-robin arbiter serialising single-word accesses onto the PSRAM ram_controller.
// Define PSRAM_ARB_TIMEOUT_EN to abort accesses that see no ram_ready within TIMEOUT busy cycles.
module psram_arbiter #(
  parameter int AW      = 23,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_a_req,
  input  logic          i_a_rw,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  output logic          o_a_ack,
  output logic          o_a_err,
  input  logic          i_b_req,
  input  logic          i_b_rw,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_wdata,
  output logic          o_b_ack,
  output logic          o_b_err,
  output logic [DW-1:0] o_rdata,
  output logic          o_grant,
  output logic          o_busy,
  input  logic          i_ram_init,
  output logic          o_ram_mem,
  output logic          o_ram_rw,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic          i_ram_ready,
  input  logic [DW-1:0] i_ram_rdata
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_mem;
  logic          r_rw;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_grant;
  logic          w_winner;
  logic          w_issue;
  logic          w_done;
  logic          w_abort;
  logic          w_expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_winner    = r_grant;
    // On a tie the requester that did not own the last access wins.
    if (i_a_req && i_b_req) begin
      w_winner = ~r_grant;
    end else if (i_a_req) begin
      w_winner = 1'b0;
    end else if (i_b_req) begin
      w_winner = 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        if (i_ram_init && (i_a_req || i_b_req)) begin
          w_issue     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (i_ram_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_expire) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem   <= 1'b0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_grant <= 1'b1;
    end else if (w_issue) begin
      r_mem   <= 1'b1;
      r_grant <= w_winner;
      r_rw    <= w_winner ? i_b_rw    : i_a_rw;
      r_addr  <= w_winner ? i_b_addr  : i_a_addr;
      r_wdata <= w_winner ? i_b_wdata : i_a_wdata;
    end else if (w_done || w_abort) begin
      r_mem <= 1'b0;
    end
  end

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LP_TMAX = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= '0;
    end else if ((r_state == S_BUSY) && !i_ram_ready && !w_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A ready arriving on the expiry cycle takes priority in the FSM.
  assign w_expire = (r_state == S_BUSY) && (r_cnt == LP_TMAX);
`else
  assign w_expire = 1'b0;
`endif

  assign o_busy      = (r_state == S_BUSY);
  assign o_grant     = r_grant;
  assign o_ram_mem   = r_mem;
  assign o_ram_rw    = r_rw;
  assign o_ram_addr  = r_addr;
  assign o_ram_wdata = r_wdata;
  assign o_rdata     = i_ram_rdata;
  assign o_a_ack     = w_done  & ~r_grant;
  assign o_b_ack     = w_done  &  r_grant;
  assign o_a_err     = w_abort & ~r_grant;
  assign o_b_err     = w_abort &  r_grant;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: init gating, write, alternation, B read, reset abort, timeout.
module tb_psram_arbiter;
  localparam int AW = 23;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_rw, b_req, b_rw;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, a_err, b_ack, b_err;
  logic [DW-1:0] rdata;
  logic          grant, busy;
  logic          ram_init, ram_mem, ram_rw, ram_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  psram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_a_req(a_req), .i_a_rw(a_rw), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_ack(a_ack), .o_a_err(a_err),
    .i_b_req(b_req), .i_b_rw(b_rw), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ack(b_ack), .o_b_err(b_err),
    .o_rdata(rdata), .o_grant(grant), .o_busy(busy),
    .i_ram_init(ram_init), .o_ram_mem(ram_mem), .o_ram_rw(ram_rw),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_ready(ram_ready), .i_ram_rdata(ram_rdata)
  );

  task automatic test_reset();
    reset = 1'b1;
    a_req = 0; a_rw = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_rw = 0; b_addr = '0; b_wdata = '0;
    ram_init = 0; ram_ready = 0; ram_rdata = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (ram_mem !== 1'b0) begin failures++; $display("FAIL reset_mem: got %b want 0", ram_mem); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (grant !== 1'b1) begin failures++; $display("FAIL reset_grant: got %b want 1", grant); end
    checks++; if ({ram_rw, ram_addr, ram_wdata} !== '0) begin failures++; $display("FAIL reset_ram_bus: rw=%b addr=%h wdata=%h want 0", ram_rw, ram_addr, ram_wdata); end
    checks++; if ({a_ack, b_ack, a_err, b_err} !== 4'b0) begin failures++; $display("FAIL reset_ack_err: got %b want 0000", {a_ack, b_ack, a_err, b_err}); end
    reset = 1'b0;
  endtask

  task automatic test_no_init();
    bit bad = 0;
    @(negedge clk);
    a_req = 1; a_rw = 0; a_addr = 23'h5; a_wdata = 16'h5; ram_init = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (ram_mem !== 1'b0 || a_ack !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL no_init_grant: ram_mem/ack rose while ram_init=0, want 0"); end
    @(negedge clk); ram_init = 1;
    @(negedge clk); #1;
    checks++; if (ram_mem !== 1'b1) begin failures++; $display("FAIL init_issue: ram_mem=%b want 1", ram_mem); end
    checks++; if (ram_addr !== 23'h5) begin failures++; $display("FAIL init_addr: got %h want 000005", ram_addr); end
    @(negedge clk); ram_ready = 1; #1;
    checks++; if (a_ack !== 1'b1) begin failures++; $display("FAIL init_ack: got %b want 1", a_ack); end
    @(negedge clk); ram_ready = 0; a_req = 0;
  endtask

  task automatic test_write();
    bit bad = 0;
    @(negedge clk);
    a_req = 1; a_rw = 0; a_addr = 23'h000010; a_wdata = 16'h0010;
    @(negedge clk); #1;
    checks++; if (ram_mem !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL wr_issue: mem=%b busy=%b want 1 1", ram_mem, busy); end
    checks++; if (grant !== 1'b0) begin failures++; $display("FAIL wr_grant: got %b want 0", grant); end
    checks++; if (ram_rw !== 1'b0 || ram_addr !== 23'h000010 || ram_wdata !== 16'h0010) begin
      failures++; $display("FAIL wr_bus: rw=%b addr=%h wdata=%h want 0 000010 0010", ram_rw, ram_addr, ram_wdata); end
    repeat (4) begin
      @(negedge clk); #1;
      if (ram_mem !== 1'b1 || a_ack !== 1'b0 || ram_addr !== 23'h000010 || ram_wdata !== 16'h0010) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL wr_hold: bus not held or early ack, want held with ack 0"); end
    @(negedge clk); ram_ready = 1; #1;
    checks++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin failures++; $display("FAIL wr_ack: a=%b b=%b want 1 0", a_ack, b_ack); end
    @(negedge clk); ram_ready = 0; a_req = 0; #1;
    checks++; if (ram_mem !== 1'b0 || busy !== 1'b0 || a_ack !== 1'b0) begin
      failures++; $display("FAIL wr_release: mem=%b busy=%b ack=%b want 0 0 0", ram_mem, busy, a_ack); end
  endtask

  task automatic test_round_robin();
    logic exp_g;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    a_req = 1; a_rw = 1; a_addr = 23'h100;
    b_req = 1; b_rw = 1; b_addr = 23'h200;
    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 10 && ram_mem !== 1'b1; w++) @(negedge clk);
      checks++; if (ram_mem !== 1'b1) begin failures++; $display("FAIL rr_wait%0d: ram_mem=%b want 1 within 10 cycles", i, ram_mem); end
      exp_g = i[0];
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr_grant%0d: got %b want %b", i, grant, exp_g); end
      checks++; if (ram_addr !== (exp_g ? 23'h200 : 23'h100)) begin failures++; $display("FAIL rr_addr%0d: got %h want %h", i, ram_addr, exp_g ? 23'h200 : 23'h100); end
      @(negedge clk); ram_ready = 1; #1;
      checks++; if (a_ack !== !exp_g || b_ack !== exp_g) begin failures++; $display("FAIL rr_ack%0d: a=%b b=%b want %b %b", i, a_ack, b_ack, !exp_g, exp_g); end
      @(negedge clk); ram_ready = 0;
      if (i == 5) begin a_req = 0; b_req = 0; end
      #1;
      checks++; if (ram_mem !== 1'b0) begin failures++; $display("FAIL rr_gap%0d: ram_mem=%b want 0", i, ram_mem); end
    end
  endtask

  task automatic test_read_b();
    @(negedge clk);
    b_req = 1; b_rw = 1; b_addr = 23'h7FFFFF;
    for (int w = 0; w < 10 && ram_mem !== 1'b1; w++) @(negedge clk);
    checks++; if (ram_mem !== 1'b1 || grant !== 1'b1) begin failures++; $display("FAIL rd_issue: mem=%b grant=%b want 1 1", ram_mem, grant); end
    checks++; if (ram_rw !== 1'b1 || ram_addr !== 23'h7FFFFF) begin failures++; $display("FAIL rd_bus: rw=%b addr=%h want 1 7fffff", ram_rw, ram_addr); end
    @(negedge clk); ram_rdata = 16'hBEEF; ram_ready = 1; #1;
    checks++; if (b_ack !== 1'b1 || a_ack !== 1'b0) begin failures++; $display("FAIL rd_ack: b=%b a=%b want 1 0", b_ack, a_ack); end
    checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_data: got %h want beef", rdata); end
    @(negedge clk); ram_ready = 0; b_req = 0;
  endtask

  task automatic test_ready_idle();
    @(negedge clk); ram_ready = 1; #1;
    checks++; if (a_ack !== 1'b0 || b_ack !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_ready: a=%b b=%b busy=%b want 0 0 0", a_ack, b_ack, busy); end
    @(negedge clk); ram_ready = 0;
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    a_req = 1; a_rw = 0; a_addr = 23'h33; a_wdata = 16'h3333;
    for (int w = 0; w < 10 && ram_mem !== 1'b1; w++) @(negedge clk);
    checks++; if (ram_mem !== 1'b1 || grant !== 1'b0) begin failures++; $display("FAIL rst_pre: mem=%b grant=%b want 1 0", ram_mem, grant); end
    @(negedge clk); reset = 1; a_req = 0; #1;
    checks++; if (ram_mem !== 1'b0 || busy !== 1'b0 || grant !== 1'b1) begin
      failures++; $display("FAIL rst_busy: mem=%b busy=%b grant=%b want 0 0 1", ram_mem, busy, grant); end
    @(negedge clk); reset = 0;
    @(negedge clk); ram_ready = 1; #1;
    checks++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin failures++; $display("FAIL rst_noack: a=%b b=%b want 0 0", a_ack, b_ack); end
    @(negedge clk); ram_ready = 0;
  endtask

  task automatic test_timeout();
    bit bad = 0;
    @(negedge clk);
    a_req = 1; a_rw = 0; a_addr = 23'h44; a_wdata = 16'h4444;
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      if (a_err !== 1'b0 || busy !== 1'b1) bad = 1;
      @(negedge clk);
    end
    checks++; if (bad) begin failures++; $display("FAIL to_early: err or idle within first 8 busy cycles, want err 0 busy 1"); end
    #1;
`ifdef PSRAM_ARB_TIMEOUT_EN
    checks++; if (a_err !== 1'b1 || a_ack !== 1'b0 || b_err !== 1'b0) begin
      failures++; $display("FAIL to_err: a_err=%b a_ack=%b b_err=%b want 1 0 0", a_err, a_ack, b_err); end
    @(negedge clk); a_req = 0; #1;
    checks++; if (ram_mem !== 1'b0 || busy !== 1'b0 || a_err !== 1'b0) begin
      failures++; $display("FAIL to_release: mem=%b busy=%b err=%b want 0 0 0", ram_mem, busy, a_err); end
`else
    checks++; if (a_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_noerr: a_err=%b busy=%b want 0 1", a_err, busy); end
    bad = 0;
    repeat (30) begin
      @(negedge clk); #1;
      if (busy !== 1'b1 || ram_mem !== 1'b1 || a_err !== 1'b0 || b_err !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL to_stuck: access left busy or err raised, want busy 1 err 0"); end
    @(negedge clk); ram_ready = 1; #1;
    checks++; if (a_ack !== 1'b1) begin failures++; $display("FAIL to_late_ack: got %b want 1", a_ack); end
    @(negedge clk); ram_ready = 0; a_req = 0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_no_init();
    test_write();
    test_round_robin();
    test_read_b();
    test_ready_idle();
    test_reset_busy();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
